// File: rtl/gestion_verin_multi.sv
// Multi-channel actuator (verin) controller: per-channel PWM with soft-start ramp,
// direction output, left/right end-stop blocking and a latched end-stop interrupt.
module gestion_verin_multi #(
  parameter int NB_CH   = 2,
  parameter int PWM_W   = 16,
  parameter int ANGLE_W = 12,
  parameter int ADDR_W  = 6
) (
  input  logic                     clk,
  input  logic                     raz_n,
  input  logic                     chip_select,
  input  logic                     write_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  input  logic [NB_CH*ANGLE_W-1:0] angle,
  output logic [NB_CH-1:0]         pwm,
  output logic [NB_CH-1:0]         sens,
  output logic [2*NB_CH-1:0]       fin_butee,
  output logic                     irq
);

  localparam int CH_W = ADDR_W - 3;
  localparam logic [2:0] REG_FREQ    = 3'd0;
  localparam logic [2:0] REG_DUTY    = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_BUTEE_G = 3'd3;
  localparam logic [2:0] REG_BUTEE_D = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  logic [CH_W-1:0] ch_idx_s;
  logic [2:0]      reg_sel_s;
  logic            wr_s;
  logic            rd_s;
  logic [31:0]     rd_word_s [2**CH_W];
  logic [NB_CH-1:0] flag_s;
  logic [31:0]     read_data_r;
  logic            irq_r;
  logic            unused_wd_s;

  assign ch_idx_s    = address[ADDR_W-1:3];
  assign reg_sel_s   = address[2:0];
  assign wr_s        = chip_select & ~write_n;
  assign rd_s        = chip_select & write_n;
  assign unused_wd_s = ^write_data;

  for (genvar k = 0; k < 2**CH_W; k++) begin : g_ch
    if (k < NB_CH) begin : g_real
      logic [PWM_W-1:0]   freq_r, duty_r, cnt_r, duty_eff_r, step_s, duty_nx_s;
      logic               en_r, sens_r, ramp_en_r, irq_en_r;
      logic [7:0]         ramp_step_r;
      logic [ANGLE_W-1:0] butee_g_r, butee_d_r, angle_q_r;
      logic               fin_g_r, fin_d_r, flag_r, pwm_r;
      logic               wr_ch_s, sens_chg_s, clr_s, fin_g_nx_s, fin_d_nx_s;
      logic               set_s, blocked_s, wrap_s;

      assign wr_ch_s    = wr_s && (ch_idx_s == CH_W'(k));
      assign sens_chg_s = wr_ch_s && (reg_sel_s == REG_CTRL) && (write_data[1] != sens_r);
      assign clr_s      = wr_ch_s && (reg_sel_s == REG_STATUS) && write_data[2];
      assign fin_g_nx_s = (angle_q_r <= butee_g_r);
      assign fin_d_nx_s = (angle_q_r >= butee_d_r);
      assign set_s      = irq_en_r && ((fin_g_nx_s && !fin_g_r) || (fin_d_nx_s && !fin_d_r));
      assign blocked_s  = sens_r ? fin_d_r : fin_g_r;
      assign wrap_s     = (cnt_r >= (freq_r - PWM_W'(1'b1)));
      assign step_s     = (ramp_step_r == 8'd0) ? PWM_W'(1'b1) : PWM_W'(ramp_step_r);

      // Bus-writable configuration registers
      always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
          freq_r      <= '0;
          duty_r      <= '0;
          en_r        <= 1'b0;
          sens_r      <= 1'b0;
          ramp_en_r   <= 1'b0;
          irq_en_r    <= 1'b0;
          ramp_step_r <= 8'd0;
          butee_g_r   <= '0;
          butee_d_r   <= {ANGLE_W{1'b1}};
        end else if (wr_ch_s) begin
          case (reg_sel_s)
            REG_FREQ:    freq_r <= write_data[PWM_W-1:0];
            REG_DUTY:    duty_r <= write_data[PWM_W-1:0];
            REG_CTRL: begin
              en_r        <= write_data[0];
              sens_r      <= write_data[1];
              ramp_en_r   <= write_data[2];
              irq_en_r    <= write_data[3];
              ramp_step_r <= write_data[15:8];
            end
            REG_BUTEE_G: butee_g_r <= write_data[ANGLE_W-1:0];
            REG_BUTEE_D: butee_d_r <= write_data[ANGLE_W-1:0];
            default:     ;
          endcase
        end
      end

      // Next effective duty at a period boundary: direct or saturating ramp
      always_comb begin
        duty_nx_s = duty_r;
        if (!ramp_en_r) begin
          duty_nx_s = duty_r;
        end else if (duty_r > duty_eff_r) begin
          duty_nx_s = ((duty_r - duty_eff_r) <= step_s) ? duty_r : (duty_eff_r + step_s);
        end else begin
          duty_nx_s = ((duty_eff_r - duty_r) <= step_s) ? duty_r : (duty_eff_r - step_s);
        end
      end

      // PWM counter, glitch-free duty update and registered pwm pin
      always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
          cnt_r      <= '0;
          duty_eff_r <= '0;
          pwm_r      <= 1'b0;
        end else begin
          if (sens_chg_s) begin
            cnt_r      <= '0;
            duty_eff_r <= '0;
          end else if (!en_r || (freq_r == '0)) begin
            cnt_r      <= '0;
            duty_eff_r <= '0;
          end else if (wrap_s) begin
            cnt_r      <= '0;
            duty_eff_r <= duty_nx_s;
          end else begin
            cnt_r <= cnt_r + PWM_W'(1'b1);
          end
          pwm_r <= en_r && (cnt_r < duty_eff_r) && !blocked_s;
        end
      end

      // Angle sampling, end-stop detection and latched interrupt flag (set wins)
      always_ff @(posedge clk or negedge raz_n) begin
        if (!raz_n) begin
          angle_q_r <= '0;
          fin_g_r   <= 1'b0;
          fin_d_r   <= 1'b0;
          flag_r    <= 1'b0;
        end else begin
          angle_q_r <= angle[k*ANGLE_W +: ANGLE_W];
          fin_g_r   <= fin_g_nx_s;
          fin_d_r   <= fin_d_nx_s;
          if (set_s) begin
            flag_r <= 1'b1;
          end else if (clr_s) begin
            flag_r <= 1'b0;
          end
        end
      end

      // Read-back word for this channel
      always_comb begin
        case (reg_sel_s)
          REG_FREQ:    rd_word_s[k] = 32'(freq_r);
          REG_DUTY:    rd_word_s[k] = 32'(duty_r);
          REG_CTRL:    rd_word_s[k] = {16'd0, ramp_step_r, 4'd0, irq_en_r, ramp_en_r, sens_r, en_r};
          REG_BUTEE_G: rd_word_s[k] = 32'(butee_g_r);
          REG_BUTEE_D: rd_word_s[k] = 32'(butee_d_r);
          REG_STATUS:  rd_word_s[k] = {16'(duty_eff_r), 13'd0, flag_r, fin_d_r, fin_g_r};
          default:     rd_word_s[k] = 32'd0;
        endcase
      end

      assign pwm[k]           = pwm_r;
      assign sens[k]          = sens_r;
      assign fin_butee[2*k+:2] = {fin_d_r, fin_g_r};
      assign flag_s[k]        = flag_r;
    end else begin : g_absent
      assign rd_word_s[k] = 32'd0;
    end
  end

  // Registered bus read data and interrupt line
  always_ff @(posedge clk or negedge raz_n) begin
    if (!raz_n) begin
      read_data_r <= 32'd0;
      irq_r       <= 1'b0;
    end else begin
      if (rd_s) begin
        read_data_r <= rd_word_s[ch_idx_s];
      end
      irq_r <= |flag_s;
    end
  end

  assign read_data = read_data_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_gestion_verin_multi.sv
// Scoreboard bench for gestion_verin_multi: register reads and PWM pulse widths
// are queued as expectations at stimulus time and compared when the DUT responds.
module tb_gestion_verin_multi;
  localparam int NB_CH = 2, PWM_W = 16, ANGLE_W = 12, ADDR_W = 6;

  logic                     clk = 1'b0;
  logic                     raz_n = 1'b0;
  logic                     chip_select = 1'b0;
  logic                     write_n = 1'b1;
  logic [ADDR_W-1:0]        address = '0;
  logic [31:0]              write_data = 32'd0;
  logic [31:0]              read_data;
  logic [NB_CH*ANGLE_W-1:0] angle = {12'd2048, 12'd2048};
  logic [NB_CH-1:0]         pwm;
  logic [NB_CH-1:0]         sens;
  logic [2*NB_CH-1:0]       fin_butee;
  logic                     irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_q[$];
  int pulse_q[$];

  gestion_verin_multi #(.NB_CH(NB_CH), .PWM_W(PWM_W), .ANGLE_W(ANGLE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .raz_n(raz_n), .chip_select(chip_select), .write_n(write_n),
    .address(address), .write_data(write_data), .read_data(read_data),
    .angle(angle), .pwm(pwm), .sens(sens), .fin_butee(fin_butee), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    address = ADDR_W'(ch * 8 + rg);
    write_data = d;
    chip_select = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chip_select = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int rg, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = ADDR_W'(ch * 8 + rg);
    chip_select = 1'b1;
    write_n = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    chip_select = 1'b0;
    check_val(tag, read_data, rd_q.pop_front());
  endtask

  task automatic count_high(input int ch, input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm[ch]) c++;
    end
  endtask

  // Width of the next ch0 pulse; -1 if none starts within the budget
  task automatic measure_pulse(output int len);
    int t = 0;
    while (!pwm[0] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!pwm[0]) begin
      len = -1;
    end else begin
      len = 0;
      while (pwm[0] && len < 400) begin
        @(negedge clk);
        len++;
      end
    end
  endtask

  task automatic check_pulses(input int n, input string tag, input bit with_status);
    int len;
    int exp;
    for (int i = 0; i < n; i++) begin
      measure_pulse(len);
      exp = pulse_q.pop_front();
      check_val(tag, 32'(len), 32'(exp));
      if (with_status) bus_read(0, 5, 32'(exp) << 16, "ramp_status");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int t;
    logic [31:0] rst_vals [6];
    rst_vals = '{32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_0FFF, 32'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_read_data", read_data, 32'd0);
    check_val("rst_pwm", 32'(pwm), 32'd0);
    check_val("rst_sens", 32'(sens), 32'd0);
    check_val("rst_fin", 32'(fin_butee), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    raz_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 6; r++)
        bus_read(ch, r, rst_vals[r], "rst_reg");

    // Basic PWM on ch0, ch1 idle
    bus_write(0, 3, 32'd100);
    bus_write(0, 4, 32'd4000);
    bus_write(0, 0, 32'd100);
    bus_write(0, 1, 32'd25);
    bus_write(0, 2, 32'h01);
    repeat (150) @(negedge clk);
    count_high(0, 400, c);
    check_val("pwm25_ch0", 32'(c), 32'd100);
    count_high(1, 200, c);
    check_val("pwm_ch1_idle", 32'(c), 32'd0);

    // Soft-start ramp 0 -> 35, step 10
    bus_write(0, 2, 32'h00);
    bus_write(0, 1, 32'd35);
    pulse_q.push_back(10); pulse_q.push_back(20);
    pulse_q.push_back(30); pulse_q.push_back(35);
    bus_write(0, 2, 32'h0A05);
    check_pulses(4, "ramp_pulse", 1'b1);

    // Left end-stop with interrupt
    bus_write(0, 1, 32'd25);
    bus_write(0, 2, 32'h09);
    repeat (5) @(negedge clk);
    @(negedge clk);
    angle[11:0] = 12'd90;
    @(negedge clk);
    check_val("fin_lat1", 32'(fin_butee[1:0]), 32'd0);
    @(negedge clk);
    check_val("fin_lat2", 32'(fin_butee[1:0]), 32'd1);
    @(negedge clk);
    check_val("irq_set", 32'(irq), 32'd1);
    count_high(0, 200, c);
    check_val("pwm_blocked", 32'(c), 32'd0);
    bus_write(0, 2, 32'h0B);
    check_val("sens_droite", 32'(sens[0]), 32'd1);
    repeat (150) @(negedge clk);
    count_high(0, 200, c);
    check_val("pwm_resumed", 32'(c), 32'd50);
    bus_read(0, 5, 32'h0019_0005, "status_irq");
    bus_write(0, 5, 32'h4);
    @(negedge clk);
    check_val("irq_clear", 32'(irq), 32'd0);
    bus_read(0, 5, 32'h0019_0001, "status_cleared");
    angle[11:0] = 12'd2048;
    repeat (3) @(negedge clk);

    // Direction change mid-ramp restarts from 0
    bus_write(0, 2, 32'h00);
    bus_write(0, 1, 32'd80);
    for (int i = 1; i <= 5; i++) pulse_q.push_back(10 * i);
    bus_write(0, 2, 32'h0A07);
    check_pulses(5, "ramp50_pulse", 1'b0);
    bus_write(0, 2, 32'h0A05);
    check_val("sens_gauche", 32'(sens[0]), 32'd0);
    bus_read(0, 5, 32'd0, "status_dir_reset");
    pulse_q.push_back(10); pulse_q.push_back(20);
    check_pulses(2, "reramp_pulse", 1'b0);

    // FREQ=0 and DUTY=FREQ edge cases
    bus_write(0, 0, 32'd0);
    repeat (5) @(negedge clk);
    count_high(0, 100, c);
    check_val("freq0_pwm", 32'(c), 32'd0);
    bus_read(0, 5, 32'd0, "freq0_status");
    bus_write(0, 2, 32'h01);
    bus_write(0, 1, 32'd100);
    bus_write(0, 0, 32'd100);
    repeat (120) @(negedge clk);
    count_high(0, 200, c);
    check_val("duty_full", 32'(c), 32'd200);

    // Absent channel and reserved registers
    bus_write(3, 0, 32'h55);
    bus_write(3, 2, 32'h01);
    bus_read(3, 0, 32'd0, "ch3_freq");
    bus_read(3, 2, 32'd0, "ch3_ctrl");
    bus_read(0, 0, 32'd100, "ch0_freq_kept");
    bus_read(1, 0, 32'd0, "ch1_freq_kept");
    bus_write(0, 6, 32'hDEAD);
    bus_read(0, 6, 32'd0, "reserved6");
    bus_read(0, 7, 32'd0, "reserved7");

    // Asynchronous reset during a pulse
    bus_write(0, 1, 32'd50);
    bus_read(0, 1, 32'd50, "duty50");
    t = 0;
    while (!pwm[0] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_val("rst_wait_pulse", 32'(pwm[0]), 32'd1);
    #2 raz_n = 1'b0;
    #1;
    check_val("async_pwm", 32'(pwm), 32'd0);
    check_val("async_read_data", read_data, 32'd0);
    check_val("async_sens", 32'(sens), 32'd0);
    @(negedge clk);
    raz_n = 1'b1;
    count_high(0, 150, c);
    check_val("post_rst_pwm", 32'(c), 32'd0);
    bus_read(0, 0, 32'd0, "post_rst_freq");
    bus_read(0, 4, 32'h0000_0FFF, "post_rst_butee_d");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
